fibo_sequencer: RTL
===================

Name: fibo_sequencer

Overview:
- Control FSM plus its own operand registers; computes the Fibonacci number F(N) for an N given on a start handshake.
- Drives the adder/register datapath: two SIZE-bit state registers, A and B, are updated once per iteration by an adder.
- Sits above the ALU and flip-flop register blocks as the top-level sequencer of the Fibonacci design.
- Returns Result, a sticky Overflow flag and a one-cycle Done pulse.

Parameters:
SIZE, 4, width of A, B and Result (arithmetic is modulo 2^SIZE)
CNT_W, 4, width of N and of the iteration counter

Ports:
Clk  input  1  system clock; all state updates on the rising edge
Rst_n  input  1  asynchronous active-low reset
Start  input  1  request; sampled only in IDLE
N  input  CNT_W  index of the Fibonacci number requested; latched when Start is accepted
Busy  output  1  high while in RUN
Done  output  1  high for exactly one cycle (DONE state)
Result  output  SIZE  F(N) mod 2^SIZE; registered
Overflow  output  1  high when the true F(N) >= 2^SIZE; registered

Behaviour:
- Reset (Rst_n=0, asynchronous, any state, including mid-operation):
  - state=IDLE; A=0, B=0, cnt=0, A_ovf=0, B_ovf=0.
  - Result=0, Overflow=0, Busy=0, Done=0.
  - Any computation in progress is aborted with no Done.
- Definition: F(0)=0, F(1)=1, F(k+1)=F(k)+F(k-1).
- IDLE:
  - Busy=0, Done=0.
  - Start=1 at an edge -> cnt<=N, A<=0, B<=1, A_ovf<=0, B_ovf<=0; state<=RUN.
  - Result and Overflow keep their previous values.
- RUN: Busy=1.
  - If cnt!=0: A<=B; B<=(A+B) truncated to SIZE; A_ovf<=B_ovf; B_ovf<=A_ovf|B_ovf|carry_out(A+B); cnt<=cnt-1.
  - If cnt==0: Result<=A, Overflow<=A_ovf, state<=DONE.
- DONE: Busy=0, Done=1 for one cycle; state<=IDLE unconditionally.
- Overflow rule: only a carry that propagates into the value ending up in A sets Overflow. A carry into B that is never shifted into A (i.e. one belonging to F(N+1)) must not set it.
- Latency: with Start accepted at edge 0, the RUN iterations occur at edges 1..N and Result is loaded at edge N+1. Done is high in the cycle after edge N+1 and returns low after edge N+2.
- Busy and Done are Moore outputs decoded from state; never both high.
- Start in RUN or DONE is ignored; it is not queued.
- Start held high continuously: after DONE->IDLE, the next edge accepts a new request, giving back-to-back runs with one IDLE cycle between Done pulses.
- N changing while busy has no effect; the latched cnt is used.
- Result/Overflow are stable from the Done cycle until the next completion; they are not cleared on Start.
- Illegal state encodings recover to IDLE on the next edge.

Test Plan:
- Reset: assert Rst_n=0 mid-RUN (N=10, after 3 iterations), release -> Busy=0, Done=0, Result=0, Overflow=0 immediately, no Done pulse.
- N=0, Start for 1 cycle -> Done high 2 cycles after acceptance, Result=0, Overflow=0. N=1 -> Result=1, Done 3 cycles after acceptance.
- SIZE=4, N=7 -> Result=13, Overflow=0. A carry into B occurs but must not flag. Busy high exactly 8 cycles.
- SIZE=4, N=8 -> Result=5 (21 mod 16), Overflow=1. N=15 -> Result=2 (610 mod 16), Overflow=1.
- Pulse Start again during RUN, and change N mid-run -> ignored: result matches the originally latched N, single Done.
- Start held high with N=6 -> Result=8 each run, Done pulses every 9 cycles. Then N=8 sets Overflow=1, and a following N=6 run clears it back to 0.

Source files
------------

// File: rtl/fibo_sequencer.sv
// fibo_sequencer
// Top-level sequencer of the Fibonacci design. Computes F(N) mod 2^SIZE for an
// index N presented with a Start request. Two SIZE-bit registers A and B walk
// the sequence one step per RUN cycle. A sticky overflow bit travels with each
// register so that overflow is reported only for the value that ends up in A.
//
// Ports:
//   Clk       - system clock, rising edge
//   Rst_n     - asynchronous active-low reset
//   Start     - request, sampled only in IDLE
//   N         - Fibonacci index, latched when Start is accepted
//   Busy      - high while iterating (RUN)
//   Done      - one-cycle completion pulse (DONE)
//   Result    - registered F(N) mod 2^SIZE
//   Overflow  - registered, high when the true F(N) >= 2^SIZE
//   dbg_state - current FSM state encoding (observation only)
//
// Handshake: Start is a level request without a ready. It is accepted on any
// rising edge where the FSM is in IDLE and Start=1. Start seen in RUN or DONE
// is dropped and is not queued. Busy=1 marks the window in which requests are
// ignored. Done marks the single cycle in which a fresh Result/Overflow first
// appears.
module fibo_sequencer #(
    parameter int SIZE  = 4,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [CNT_W-1:0] N,
    output logic             Busy,
    output logic             Done,
    output logic [SIZE-1:0]  Result,
    output logic             Overflow,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SIZE-1:0]  a;
    logic [SIZE-1:0]  b;
    logic             a_ovf;
    logic             b_ovf;
    logic [CNT_W-1:0] cnt;
    logic [SIZE:0]    sum;

    // One extra bit so the carry out of A+B is visible.
    assign sum = {1'b0, a} + {1'b0, b};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and Moore outputs. The unused encoding falls to the default
    // branch and returns to IDLE on the next edge.
    always_comb begin
        state_nxt = ST_IDLE;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = Start ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                Busy      = 1'b1;
                state_nxt = (cnt == '0) ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                Done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign dbg_state = state;

    // Datapath. A overflow bit follows its value as it shifts from B to A.
    // That way a carry that only ever lands in B, which happens on the step
    // that forms F(N+1), never reaches Overflow.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a        <= '0;
            b        <= '0;
            a_ovf    <= 1'b0;
            b_ovf    <= 1'b0;
            cnt      <= '0;
            Result   <= '0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        cnt   <= N;
                        a     <= '0;
                        b     <= {{(SIZE-1){1'b0}}, 1'b1};
                        a_ovf <= 1'b0;
                        b_ovf <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cnt != '0) begin
                        a     <= b;
                        b     <= sum[SIZE-1:0];
                        a_ovf <= b_ovf;
                        b_ovf <= a_ovf | b_ovf | sum[SIZE];
                        cnt   <= cnt - 1'b1;
                    end else begin
                        Result   <= a;
                        Overflow <= a_ovf;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
